// File: rtl/postproc_pkg.sv
// Shared types and helpers for the FFT postprocess chain.
// Tags ride alongside data through every pipelined postprocess block.
package postproc_pkg;

  localparam int IDX_W = 16;

  function automatic int pwr_w(input int w);
    return 2 * w;
  endfunction

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
    logic             first;
    logic             last;
    logic             in_win;
    logic             err;
  } tag_t;

  function automatic logic in_window(
    input logic [IDX_W-1:0] idx,
    input int               lo,
    input int               hi
  );
    return (int'(idx) >= lo) && (int'(idx) <= hi);
  endfunction

endpackage

// File: rtl/mag_sq.sv
// Two-stage registered |X|^2 = re^2 + im^2 with a pass-through tag.
// Stage 1 holds the squares, stage 2 holds their unsigned sum.
module mag_sq
  import postproc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  tag_t                      i_tag,
  input  logic signed [WIDTH-1:0]   i_re,
  input  logic signed [WIDTH-1:0]   i_im,
  output tag_t                      o_tag,
  output logic [pwr_w(WIDTH)-1:0]   o_pwr
);

  localparam int PW = pwr_w(WIDTH);

  logic signed [PW-1:0] re_x;
  logic signed [PW-1:0] im_x;
  logic signed [PW-1:0] sq_re_d;
  logic signed [PW-1:0] sq_re_q;
  logic signed [PW-1:0] sq_im_d;
  logic signed [PW-1:0] sq_im_q;
  logic [PW-1:0]        pwr_d;
  logic [PW-1:0]        pwr_q;
  tag_t                 t1_d;
  tag_t                 t1_q;
  tag_t                 t2_d;
  tag_t                 t2_q;

  always_comb begin
    re_x    = PW'(i_re);
    im_x    = PW'(i_im);
    sq_re_d = re_x * re_x;
    sq_im_d = im_x * im_x;
    t1_d    = i_tag;
    // Both squares are non-negative, so the sum cannot exceed 2^(PW-1).
    pwr_d   = $unsigned(sq_re_q) + $unsigned(sq_im_q);
    t2_d    = t1_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sq_re_q <= '0;
      sq_im_q <= '0;
      pwr_q   <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
    end else begin
      sq_re_q <= sq_re_d;
      sq_im_q <= sq_im_d;
      pwr_q   <= pwr_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
    end
  end

  assign o_tag = t2_q;
  assign o_pwr = pwr_q;

endmodule

// File: rtl/frame_peak.sv
// Per-frame peak power search over a bin window of an FFT stream.
// Emits one (power, index, err) result three cycles after frame end.
module frame_peak
  import postproc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NFFT_LOG = 10,
  parameter int BIN_MIN  = 1,
  parameter int BIN_MAX  = 511
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_vld,
  input  logic signed [WIDTH-1:0]   i_re,
  input  logic signed [WIDTH-1:0]   i_im,
  input  logic                      i_last,
  output logic                      o_vld,
  output logic [2*WIDTH-1:0]        o_power,
  output logic [NFFT_LOG-1:0]       o_index,
  output logic                      o_err
);

  localparam int PW = pwr_w(WIDTH);
  localparam logic [NFFT_LOG-1:0] LAST_BIN = '1;
  localparam logic [NFFT_LOG-1:0] MIN_IDX  = NFFT_LOG'(BIN_MIN);

  logic [NFFT_LOG-1:0] cnt_d;
  logic [NFFT_LOG-1:0] cnt_q;
  logic                end_hit;
  logic                fe;
  tag_t                in_tag;

  tag_t                s2_tag;
  logic [PW-1:0]       s2_pwr;

  logic                s3_vld_d;
  logic                s3_vld_q;
  logic                s3_last_d;
  logic                s3_last_q;
  logic                s3_err_d;
  logic                s3_err_q;

  logic                base_ok;
  logic [PW-1:0]       best_pwr_d;
  logic [PW-1:0]       best_pwr_q;
  logic [NFFT_LOG-1:0] best_idx_d;
  logic [NFFT_LOG-1:0] best_idx_q;
  logic                best_ok_d;
  logic                best_ok_q;

  logic                o_vld_d;
  logic                o_vld_q;
  logic [PW-1:0]       o_power_d;
  logic [PW-1:0]       o_power_q;
  logic [NFFT_LOG-1:0] o_index_d;
  logic [NFFT_LOG-1:0] o_index_q;
  logic                o_err_d;
  logic                o_err_q;

  always_comb begin
    end_hit = (cnt_q == LAST_BIN);
    fe      = i_last | end_hit;
    in_tag  = '0;
    cnt_d   = cnt_q;
    if (i_vld) begin
      in_tag.vld    = 1'b1;
      in_tag.idx    = IDX_W'(cnt_q);
      in_tag.first  = (cnt_q == '0);
      in_tag.last   = fe;
      in_tag.in_win = in_window(IDX_W'(cnt_q), BIN_MIN, BIN_MAX);
      in_tag.err    = i_last ^ end_hit;
      cnt_d         = fe ? '0 : cnt_q + NFFT_LOG'(1);
    end
  end

  mag_sq #(
    .WIDTH (WIDTH)
  ) u_mag_sq (
    .clk   (clk),
    .rstn  (rstn),
    .i_tag (in_tag),
    .i_re  (i_re),
    .i_im  (i_im),
    .o_tag (s2_tag),
    .o_pwr (s2_pwr)
  );

  always_comb begin
    best_pwr_d = best_pwr_q;
    best_idx_d = best_idx_q;
    best_ok_d  = best_ok_q;
    // First-of-frame forgets the previous frame before comparing.
    base_ok    = best_ok_q & ~s2_tag.first;
    s3_vld_d   = s2_tag.vld;
    s3_last_d  = s2_tag.last;
    s3_err_d   = s2_tag.err;
    if (s2_tag.vld) begin
      best_ok_d = base_ok;
      if (s2_tag.in_win && (!base_ok || (s2_pwr > best_pwr_q))) begin
        best_pwr_d = s2_pwr;
        best_idx_d = s2_tag.idx[NFFT_LOG-1:0];
        best_ok_d  = 1'b1;
      end
    end
  end

  always_comb begin
    o_vld_d   = s3_vld_q & s3_last_q;
    o_power_d = o_power_q;
    o_index_d = o_index_q;
    o_err_d   = o_err_q;
    if (o_vld_d) begin
      o_power_d = best_ok_q ? best_pwr_q : '0;
      o_index_d = best_ok_q ? best_idx_q : MIN_IDX;
      o_err_d   = s3_err_q | ~best_ok_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q      <= '0;
      s3_vld_q   <= 1'b0;
      s3_last_q  <= 1'b0;
      s3_err_q   <= 1'b0;
      best_pwr_q <= '0;
      best_idx_q <= '0;
      best_ok_q  <= 1'b0;
      o_vld_q    <= 1'b0;
      o_power_q  <= '0;
      o_index_q  <= '0;
      o_err_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      s3_vld_q   <= s3_vld_d;
      s3_last_q  <= s3_last_d;
      s3_err_q   <= s3_err_d;
      best_pwr_q <= best_pwr_d;
      best_idx_q <= best_idx_d;
      best_ok_q  <= best_ok_d;
      o_vld_q    <= o_vld_d;
      o_power_q  <= o_power_d;
      o_index_q  <= o_index_d;
      o_err_q    <= o_err_d;
    end
  end

  assign o_vld   = o_vld_q;
  assign o_power = o_power_q;
  assign o_index = o_index_q;
  assign o_err   = o_err_q;

endmodule

// File: tb/tb_frame_peak.sv
// Directed bench for frame_peak with an expected-result queue.
// NFFT=8, window 1..6.
module tb_frame_peak;

  localparam int W    = 16;
  localparam int NL   = 3;
  localparam int BMIN = 1;
  localparam int BMAX = 6;
  localparam int N    = 8;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                i_vld = 1'b0;
  logic                i_last = 1'b0;
  logic signed [W-1:0] i_re = '0;
  logic signed [W-1:0] i_im = '0;
  logic                o_vld;
  logic                o_err;
  logic [2*W-1:0]      o_power;
  logic [NL-1:0]       o_index;

  always #5 clk = ~clk;

  frame_peak #(
    .WIDTH    (W),
    .NFFT_LOG (NL),
    .BIN_MIN  (BMIN),
    .BIN_MAX  (BMAX)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_vld   (i_vld),
    .i_re    (i_re),
    .i_im    (i_im),
    .i_last  (i_last),
    .o_vld   (o_vld),
    .o_power (o_power),
    .o_index (o_index),
    .o_err   (o_err)
  );

  typedef struct {
    logic [2*W-1:0] pwr;
    logic [NL-1:0]  idx;
    logic           err;
    int             due;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mcyc    = 0;
  int   fre[N];
  int   fim[N];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    mcyc++;
    if (o_vld) begin
      if (sb.size() == 0) begin
        chk("unexpected_vld", o_vld, 0);
      end else begin
        e = sb.pop_front();
        chk("power", o_power, e.pwr);
        chk("index", o_index, e.idx);
        chk("err", o_err, e.err);
        chk("latency", mcyc, e.due);
      end
    end
  end

  task automatic push_exp(input int n, input bit use_last);
    exp_t   e;
    longint best;
    longint p;
    int     bi;
    best = -1;
    bi   = BMIN;
    for (int k = 0; k < n; k++) begin
      if (k >= BMIN && k <= BMAX) begin
        p = longint'(fre[k]) * longint'(fre[k])
          + longint'(fim[k]) * longint'(fim[k]);
        if (p > best) begin
          best = p;
          bi   = k;
        end
      end
    end
    e.pwr = (best < 0) ? '0 : (2*W)'(best);
    e.idx = NL'(bi);
    e.err = (best < 0) || (use_last != (n == N));
    e.due = mcyc + 4;
    sb.push_back(e);
  endtask

  task automatic send(input int n, input bit use_last, input int gmax);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i_vld  = 1'b1;
      i_re   = W'(fre[k]);
      i_im   = W'(fim[k]);
      i_last = use_last && (k == n - 1);
      if (k == n - 1) push_exp(n, use_last);
      if (k < n - 1 && gmax > 0) begin
        int g;
        g = $urandom_range(gmax, 0);
        repeat (g) begin
          @(negedge clk);
          i_vld  = 1'b0;
          i_re   = W'($urandom);
          i_im   = W'($urandom);
          i_last = 1'($urandom);
        end
      end
    end
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(negedge clk);
      i_vld  = 1'b0;
      i_last = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 30) begin
      idle(1);
      t++;
    end
    chk("drain_empty", sb.size(), 0);
    sb.delete();
    idle(2);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_vld"}, o_vld, 0);
    chk({tag, "_power"}, o_power, 0);
    chk({tag, "_index"}, o_index, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  initial begin
    idle(3);
    chk_zero_outputs("reset");
    rstn = 1'b1;
    idle(2);

    fre = '{0, 1, 2, 7, 3, 0, 0, 9};
    fim = '{default: 0};
    send(8, 1'b1, 0);
    drain();

    fre = '{0, 0, 4, 0, 0, 4, 0, 0};
    fim = '{0, 0, -4, 0, 0, -4, 0, 0};
    send(8, 1'b1, 0);
    drain();

    fre = '{3, 100, 2, 1, 0, 5, 4, 0};
    fim = '{default: 0};
    send(8, 1'b1, 0);
    fre = '{90, 1, 2, 3, 1, 2, 8, 20};
    send(8, 1'b1, 0);
    drain();

    fre = '{9, 3, 7, 2, 5, 80, 80, 80};
    fim = '{0, 1, 0, 1, 0, 0, 0, 0};
    send(5, 1'b1, 0);
    fre = '{50, 1, 2, 3, 4, 5, 6, 7};
    fim = '{default: 0};
    send(8, 1'b1, 0);
    drain();

    fre = '{0, 0, 0, 0, 0, -32768, 0, 0};
    fim = '{0, 0, 0, 0, 0, -32768, 0, 0};
    send(8, 1'b1, 0);
    drain();

    fre = '{1, 2, 3, 4, 3, 2, 1, 0};
    fim = '{default: 0};
    send(8, 1'b0, 0);
    drain();

    fre = '{100, 0, 0, 0, 0, 0, 0, 0};
    send(1, 1'b1, 0);
    drain();

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) begin
        fre[k] = int'($urandom_range(65535, 0)) - 32768;
        fim[k] = int'($urandom_range(65535, 0)) - 32768;
      end
      send(8, 1'b1, 0);
      send(8, 1'b1, 3);
      drain();
    end

    fre = '{0, 1, 2, 7, 3, 0, 0, 9};
    fim = '{default: 0};
    send(8, 1'b1, 3);
    drain();

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_vld  = 1'b1;
      i_re   = W'(fre[k]);
      i_im   = W'(fim[k]);
      i_last = 1'b0;
    end
    @(negedge clk);
    rstn   = 1'b0;
    i_vld  = 1'b1;
    i_re   = W'(fre[4]);
    i_last = 1'b1;
    idle(2);
    chk_zero_outputs("midreset");
    rstn = 1'b1;
    idle(6);
    chk("midreset_no_vld", sb.size(), 0);
    fre = '{0, 6, 2, 1, 3, 11, 0, 9};
    send(8, 1'b1, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
